// File: rtl/spi_frame_receiver.sv
// SPI slave receiver: oversamples sclk/cs_n/sdi in the clk domain, assembles a
// chip-select framed packet of NUM_WORDS x WORD_W bits and publishes it atomically.
module spi_frame_receiver #(
   parameter int unsigned WORD_W      = 16,
   parameter int unsigned NUM_WORDS   = 2,
   parameter int unsigned SAMPLE_EDGE = 0,
   parameter int unsigned MSB_FIRST   = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          sclk,
   input  logic                          cs_n,
   input  logic                          sdi,
   output logic [WORD_W*NUM_WORDS-1:0]   words,
   output logic                          frame_valid,
   output logic                          frame_err,
   output logic                          busy,
   output logic [7:0]                    frame_cnt
);

   localparam int unsigned FRAME_BITS = WORD_W * NUM_WORDS;
   localparam int unsigned CW         = $clog2(FRAME_BITS + 1);
   localparam int unsigned PW         = $clog2(FRAME_BITS);
   localparam int unsigned BW         = $clog2(WORD_W);
   localparam int unsigned WIW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   typedef enum logic [1:0] {WAIT_CS, IDLE, RECV, OVERRUN} state_t;

   state_t                  state;
   logic [2:0]              sclk_sr;
   logic [2:0]              cs_sr;
   logic [1:0]              sdi_sr;
   logic                    smp_q;
   logic                    bit_q;
   logic                    rise_q;
   logic                    fall_q;
   logic                    cs_hi_q;
   logic [FRAME_BITS-1:0]   shreg;
   logic [FRAME_BITS-1:0]   shreg_nx;
   logic [CW-1:0]           bit_cnt;
   logic [CW-1:0]           cnt_nx;
   logic [BW-1:0]           bit_idx;
   logic [BW-1:0]           bit_off;
   logic [WIW-1:0]          word_idx;
   logic [PW-1:0]           pos;
   logic                    sclk_edge;
   logic                    ovf;
   logic                    store;

   // Synchronizers, edge-detect stage and registered input events.
   // cs_n sync resets low so a select held through reset is never seen as a fresh fall.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sr <= '0;
         cs_sr   <= '0;
         sdi_sr  <= '0;
         smp_q   <= 1'b0;
         bit_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         cs_hi_q <= 1'b0;
      end else begin
         sclk_sr <= {sclk_sr[1:0], sclk};
         cs_sr   <= {cs_sr[1:0], cs_n};
         sdi_sr  <= {sdi_sr[0], sdi};
         smp_q   <= sclk_edge & ~cs_sr[1];
         bit_q   <= sdi_sr[1];
         rise_q  <= cs_sr[1] & ~cs_sr[2];
         fall_q  <= ~cs_sr[1] & cs_sr[2];
         cs_hi_q <= cs_sr[1];
      end
   end

   // Bit placement and the post-sample view of the frame used on completion.
   always_comb begin
      sclk_edge = (SAMPLE_EDGE != 0) ? (sclk_sr[1] & ~sclk_sr[2]) : (~sclk_sr[1] & sclk_sr[2]);
      ovf       = smp_q && (bit_cnt == CW'(FRAME_BITS));
      store     = smp_q && !ovf;
      bit_off   = (MSB_FIRST != 0) ? (BW'(WORD_W - 1) - bit_idx) : bit_idx;
      pos       = PW'(word_idx) * PW'(WORD_W) + PW'(bit_off);
      shreg_nx  = shreg;
      cnt_nx    = bit_cnt;
      if (store) begin
         shreg_nx[pos] = bit_q;
         cnt_nx        = bit_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= WAIT_CS;
         words       <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         busy        <= 1'b0;
         frame_cnt   <= 8'd0;
         shreg       <= '0;
         bit_cnt     <= '0;
         bit_idx     <= '0;
         word_idx    <= '0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         case (state)
            WAIT_CS: begin
               if (cs_hi_q) state <= IDLE;
            end
            IDLE: begin
               if (fall_q) begin
                  bit_cnt  <= '0;
                  bit_idx  <= '0;
                  word_idx <= '0;
                  busy     <= 1'b1;
                  state    <= RECV;
               end
            end
            RECV: begin
               if (store) begin
                  shreg   <= shreg_nx;
                  bit_cnt <= cnt_nx;
                  if (bit_idx == BW'(WORD_W - 1)) begin
                     bit_idx  <= '0;
                     word_idx <= word_idx + WIW'(1);
                  end else begin
                     bit_idx <= bit_idx + BW'(1);
                  end
               end
               // A bit arriving with the rising select is counted before judging the frame.
               if (rise_q) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (ovf) begin
                     frame_err <= 1'b1;
                  end else if (cnt_nx == CW'(FRAME_BITS)) begin
                     words       <= shreg_nx;
                     frame_valid <= 1'b1;
                     frame_cnt   <= frame_cnt + 8'd1;
                  end else if (cnt_nx != '0) begin
                     frame_err <= 1'b1;
                  end
               end else if (ovf) begin
                  state <= OVERRUN;
               end
            end
            OVERRUN: begin
               if (rise_q) begin
                  frame_err <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= WAIT_CS;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Scoreboard bench for spi_frame_receiver: two instances (16x2 MSB-first falling,
// 8x4 LSB-first rising) share sclk/sdi and have separate chip selects.
module tb_spi_frame_receiver;

   logic        clk = 1'b0;
   logic        reset;
   logic        sclk;
   logic        sdi;
   logic        cs0;
   logic        cs1;
   logic [31:0] words0;
   logic [31:0] words1;
   logic        fv0, fe0, busy0;
   logic        fv1, fe1, busy1;
   logic [7:0]  cnt0, cnt1;

   always #5 clk = ~clk;

   spi_frame_receiver #(.WORD_W(16), .NUM_WORDS(2), .SAMPLE_EDGE(0), .MSB_FIRST(1)) u_dut0 (
      .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs0), .sdi(sdi),
      .words(words0), .frame_valid(fv0), .frame_err(fe0), .busy(busy0), .frame_cnt(cnt0));

   spi_frame_receiver #(.WORD_W(8), .NUM_WORDS(4), .SAMPLE_EDGE(1), .MSB_FIRST(0)) u_dut1 (
      .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs1), .sdi(sdi),
      .words(words1), .frame_valid(fv1), .frame_err(fe1), .busy(busy1), .frame_cnt(cnt1));

   typedef struct {
      logic        err;
      logic [31:0] w;
      logic [7:0]  c;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] mw [2];
   logic [7:0]  mc [2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // dut0 samples on the falling edge, dut1 on the rising edge; data settles a phase early.
   task automatic send_bit(input int sel, input bit b);
      sdi  = b;
      sclk = (sel == 0) ? 1'b1 : 1'b0;
      wait_clk(2);
      sclk = ~sclk;
      wait_clk(2);
   endtask

   // One select of n bits; the first 32 follow the word format, extras are random.
   // reset_at >= 0 pulses reset before that bit and the frame is expected to vanish.
   task automatic frame(input int sel, input logic [31:0] data, input int n, input int reset_at);
      int          wlen;
      bit          msb;
      bit          bits[$];
      bit          aborted;
      exp_t        e;
      logic [31:0] wd;
      int          waited;
      wlen    = (sel == 0) ? 16 : 8;
      msb     = (sel == 0);
      aborted = 1'b0;
      for (int k = 0; k < 32 / wlen; k++) begin
         wd = data >> (k * wlen);
         for (int j = 0; j < wlen; j++) bits.push_back(msb ? wd[wlen-1-j] : wd[j]);
      end
      while (bits.size() < n) bits.push_back(1'($urandom));
      while (bits.size() > n) void'(bits.pop_back());

      if (sel == 0) cs0 = 1'b0; else cs1 = 1'b0;
      wait_clk(2);
      for (int i = 0; i < n; i++) begin
         if (i == reset_at) begin
            reset = 1'b1;
            wait_clk(1);
            reset = 1'b0;
            mw[0] = '0; mw[1] = '0; mc[0] = '0; mc[1] = '0;
            aborted = 1'b1;
            check("reset_words", 64'(words0), 64'(0));
            check("reset_cnt", 64'(cnt0), 64'(0));
            check("reset_busy", 64'(busy0), 64'(0));
         end
         send_bit(sel, bits[i]);
      end
      wait_clk(2);
      if (n > 0 && !aborted) check("busy_in_frame", 64'((sel == 0) ? busy0 : busy1), 64'(1));

      if (!aborted && n > 0) begin
         if (n == 32) begin
            mw[sel] = data;
            mc[sel] = mc[sel] + 8'd1;
            e.err = 1'b0;
         end else begin
            e.err = 1'b1;
         end
         e.w = mw[sel];
         e.c = mc[sel];
         if (sel == 0) q0.push_back(e); else q1.push_back(e);
      end

      if (sel == 0) cs0 = 1'b1; else cs1 = 1'b1;
      wait_clk(6);
      waited = 0;
      while (((sel == 0) ? q0.size() : q1.size()) != 0 && waited < 20) begin
         wait_clk(1);
         waited++;
      end
      check("pulse_arrived", 64'((sel == 0) ? q0.size() : q1.size()), 64'(0));
      if (sel == 0) q0.delete(); else q1.delete();
   endtask

   task automatic mon(input int sel, input logic v, input logic e, input logic [31:0] w,
                      input logic [7:0] c, input logic b);
      exp_t x;
      int   sz;
      check("pulse_exclusive", 64'(v & e), 64'(0));
      sz = (sel == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_pulse dut%0d: valid=%0b err=%0b, none expected", sel, v, e);
      end else begin
         if (sel == 0) x = q0.pop_front(); else x = q1.pop_front();
         check("pulse_kind_err", 64'(e), 64'(x.err));
         check("words", 64'(w), 64'(x.w));
         check("frame_cnt", 64'(c), 64'(x.c));
         check("busy_at_pulse", 64'(b), 64'(0));
      end
   endtask

   // Monitor: every pulse must match the head of that instance's queue.
   always @(negedge clk) begin
      if (fv0 || fe0) mon(0, fv0, fe0, words0, cnt0, busy0);
      if (fv1 || fe1) mon(1, fv1, fe1, words1, cnt1, busy1);
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      cs0   = 1'b1;
      cs1   = 1'b1;
      sclk  = 1'b0;
      sdi   = 1'b0;
      mw[0] = '0; mw[1] = '0; mc[0] = '0; mc[1] = '0;
      wait_clk(3);
      check("reset_words0", 64'(words0), 64'(0));
      check("reset_cnt0", 64'(cnt0), 64'(0));
      check("reset_valid0", 64'(fv0), 64'(0));
      check("reset_err0", 64'(fe0), 64'(0));
      check("reset_busy0", 64'(busy0), 64'(0));
      check("reset_words1", 64'(words1), 64'(0));
      reset = 1'b0;
      wait_clk(6);

      // sclk activity with both selects high must be ignored
      for (int i = 0; i < 10; i++) begin
         sdi  = 1'($urandom);
         sclk = ~sclk;
         wait_clk(2);
      end
      check("idle_busy0", 64'(busy0), 64'(0));
      check("idle_busy1", 64'(busy1), 64'(0));

      frame(0, 32'hABCD1234, 32, -1);
      check("first_words", 64'(words0), 64'(32'hABCD1234));
      check("first_cnt", 64'(cnt0), 64'(1));

      frame(0, 32'h5555AAAA, 20, -1);
      check("short_holds_words", 64'(words0), 64'(32'hABCD1234));
      check("short_holds_cnt", 64'(cnt0), 64'(1));
      frame(0, 32'h00020001, 32, -1);
      check("second_words", 64'(words0), 64'(32'h00020001));

      frame(0, 32'hFFFF0000, 33, -1);
      frame(0, 32'h0, 0, -1);
      check("empty_busy", 64'(busy0), 64'(0));

      frame(1, 32'h44332211, 32, -1);
      check("lsb_rise_words", 64'(words1), 64'(32'h44332211));
      for (int i = 0; i < 4; i++) frame(1, $urandom, ($urandom_range(0, 3) == 0) ? 31 : 32, -1);

      for (int i = 0; i < 20; i++)
         frame(0, $urandom, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : 32, -1);

      frame(0, 32'hDEADBEEF, 32, 16);
      check("post_reset_cnt", 64'(cnt0), 64'(0));

      for (int i = 0; i < 256; i++) frame(0, $urandom, 32, -1);
      check("cnt_wrapped", 64'(cnt0), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
